riscv_regfile: RTL and testbench
================================

// Module: riscv_regfile
// PURPOSE
//   RV64 integer register file: 32 x 64-bit registers, two combinational read ports, one synchronous write port.
//   Sits in the datapath decode stage; Ra/Rb come from rs1/rs2, Rw/Din/WE from writeback.
//   Register x0 is hardwired to zero.
// PARAMETERS
//   XLEN      64  data width of each register and of Din/Da/Db
//   NREGS     32  number of architectural registers (power of two)
//   AW        5   address width, equal to log2(NREGS)
// PORTS
//   CLK    in   1     single clock; the write port samples on rising edge
//   RST_N  in   1     asynchronous, active-low reset
//   Ra     in   AW    read address, port A
//   Rb     in   AW    read address, port B
//   Rw     in   AW    write address
//   WE     in   1     write enable, active high
//   Din    in   XLEN  write data
//   Da     out  XLEN  read data, port A
//   Db     out  XLEN  read data, port B
// BEHAVIOUR
//   - Reset: RST_N low clears all registers to 0 immediately, without waiting for a clock edge.
//     Da and Db read 0 while RST_N is low. Writes are blocked while RST_N is low.
//   - Write: on posedge CLK with RST_N high, WE=1 and Rw!=0: reg[Rw] <= Din.
//     WE=0 means no state change. Din and Rw are don't-care when WE=0.
//   - x0: a write to Rw=0 is discarded. Da=0 when Ra=0; Db=0 when Rb=0.
//   - Read: Da=reg[Ra] and Db=reg[Rb], combinational with zero latency.
//     A written value appears on the read ports after the writing edge.
//   - Same-cycle read/write of the same address, without the bypass: the read returns the
//     old value until the edge, then the new value.
//   - Both ports may address the same register at once; both return the same value.
//   - X/unknown inputs: unknown Ra or Rb may drive X on that port only. A write with WE=1
//     is committed only when Rw is known.
//   - Reset asserted mid-operation wins over a coincident write edge; the register ends at 0.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - Write-through forwarding. When WE=1, Rw!=0 and Ra==Rw, Da=Din combinationally in the
//       same cycle. The same rule applies to Rb and Db.
//     - Bypass is suppressed while RST_N is low.
//   REGFILE_BYPASS_EN undefined:
//     - Plain behaviour described above; Din has no combinational path to Da/Db.
// STRUCTURE
//   - Shared package riscv_pkg:
//     - localparam XLEN=64, NREGS=32, AW=5
//     - typedef logic [XLEN-1:0] xlen_t
//     - typedef logic [AW-1:0] reg_addr_t
//     - localparam reg_addr_t REG_ZERO = '0
//   - One sub-module: regfile_read_port. It is instantiated twice and contains the
//     address decode, the x0 zero-forcing and the optional bypass mux.
//   - The storage array and write logic stay in riscv_regfile.
// TESTING
//   1. RST_N=0, then 1; Ra=5, Rb=31 -> Da=0, Db=0.
//   2. WE=1, Rw=1, Din=234, one posedge; Rb=1 -> Db=234. Then Ra=18, Rw=18, Din=672,
//      posedge -> Da=672 and Db still 234.
//   3. WE=1, Rw=0, Din=64'hDEAD_BEEF, posedge; Ra=0 -> Da=0.
//   4. WE=0, Rw=3, Din=99, posedge; Ra=3 -> Da is unchanged (0 after reset).
//   5. Same-cycle Ra=Rw=7, WE=1, Din=55 before the edge:
//      - Bypass enabled: Da=55 before the edge.
//      - Bypass disabled: Da=old value before the edge, 55 after it.
//   6. x1=234 and x18=672 are written; pulse RST_N low between clock edges -> Da/Db read 0
//      immediately and stay 0 after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 integer datapath types and sizes for the register file slice.
// Optional feature elsewhere in this slice: REGFILE_BYPASS_EN (write-through forwarding).
package riscv_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: address decode, x0 forcing, optional bypass.
// Define REGFILE_BYPASS_EN to forward the in-flight write data to this port.
module regfile_read_port
  import riscv_pkg::*;
(
  input  logic      rst_n,
  input  reg_addr_t addr,
  input  xlen_t     regs [NREGS],
`ifdef REGFILE_BYPASS_EN
  input  logic      we,
  input  reg_addr_t rw,
  input  xlen_t     din,
`endif
  output xlen_t     data
);

  always_comb begin
    data = '0;
    // Reset holds the port at zero, which also suppresses any forwarding.
    if (rst_n && (addr != REG_ZERO)) begin
      data = regs[addr];
`ifdef REGFILE_BYPASS_EN
      if (we && (rw == addr)) begin
        data = din;
      end
`endif
    end
  end

endmodule

// File: rtl/riscv_regfile.sv
// RV64 integer register file: 32 x 64-bit, two combinational read ports, one write port.
// Build with REGFILE_BYPASS_EN to forward write data to matching read ports in the same cycle.
module riscv_regfile
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t ra,
  input  reg_addr_t rb,
  input  reg_addr_t rw,
  input  logic      we,
  input  xlen_t     din,
  output xlen_t     da,
  output xlen_t     db
);

  xlen_t regs_view [NREGS];

  // x0 has no storage; it is a constant zero in the read view.
  assign regs_view[0] = '0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    xlen_t q_reg;

    // An unknown rw makes the decode compare unknown, so the write is not taken.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_reg <= '0;
      end else if (we && (rw == reg_addr_t'(gi))) begin
        q_reg <= din;
      end
    end

    assign regs_view[gi] = q_reg;
  end

  regfile_read_port u_port_a (
    .rst_n (rst_n),
    .addr  (ra),
    .regs  (regs_view),
`ifdef REGFILE_BYPASS_EN
    .we    (we),
    .rw    (rw),
    .din   (din),
`endif
    .data  (da)
  );

  regfile_read_port u_port_b (
    .rst_n (rst_n),
    .addr  (rb),
    .regs  (regs_view),
`ifdef REGFILE_BYPASS_EN
    .we    (we),
    .rw    (rw),
    .din   (din),
`endif
    .data  (db)
  );

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed self-checking bench for riscv_regfile; expectations follow REGFILE_BYPASS_EN.
module tb_riscv_regfile;
  import riscv_pkg::*;

  logic      clk;
  logic      rst_n;
  reg_addr_t ra;
  reg_addr_t rb;
  reg_addr_t rw;
  logic      we;
  xlen_t     din;
  xlen_t     da;
  xlen_t     db;

  int n_vec;
  int n_err;

  riscv_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ra    (ra),
    .rb    (rb),
    .rw    (rw),
    .we    (we),
    .din   (din),
    .da    (da),
    .db    (db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input xlen_t obs, input xlen_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ra = 5'd0; rb = 5'd0; rw = 5'd0; we = 1'b0; din = '0;

    // Writes are blocked during reset.
    #2;
    we = 1'b1; rw = 5'd2; din = 64'd77; ra = 5'd2;
    #1;
    check("rst_read_a", da, 64'd0);
    edge_step();
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_write_blocked", da, 64'd0);

    // Step 1: reset state.
    ra = 5'd5; rb = 5'd31;
    #1;
    check("reset_x5", da, 64'd0);
    check("reset_x31", db, 64'd0);

    // Step 2: basic writes.
    we = 1'b1; rw = 5'd1; din = 64'd234; rb = 5'd1;
    edge_step();
    we = 1'b0;
    #1;
    check("write_x1", db, 64'd234);
    we = 1'b1; ra = 5'd18; rw = 5'd18; din = 64'd672;
    edge_step();
    we = 1'b0; din = '0;
    #1;
    check("write_x18", da, 64'd672);
    check("x1_kept", db, 64'd234);

    // Step 3: x0 discards writes.
    we = 1'b1; rw = 5'd0; din = 64'hDEAD_BEEF; ra = 5'd0; rb = 5'd0;
    #1;
    check("x0_before_edge", da, 64'd0);
    edge_step();
    we = 1'b0;
    #1;
    check("x0_a", da, 64'd0);
    check("x0_b", db, 64'd0);

    // Step 4: WE=0 leaves state unchanged.
    we = 1'b0; rw = 5'd3; din = 64'd99; ra = 5'd3;
    edge_step();
    #1;
    check("we0_x3", da, 64'd0);

    // Step 5: same-cycle read/write of x7.
    ra = 5'd7; rw = 5'd7; din = 64'd55; we = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x7_pre_edge_bypass", da, 64'd55);
`else
    check("x7_pre_edge_old", da, 64'd0);
`endif
    edge_step();
    we = 1'b0; din = '0;
    #1;
    check("x7_post_edge", da, 64'd55);

    // Highest register and both ports on one address.
    we = 1'b1; rw = 5'd31; din = 64'hFFFF_FFFF_FFFF_FFFF;
    edge_step();
    we = 1'b0;
    ra = 5'd31; rb = 5'd31;
    #1;
    check("x31_a", da, 64'hFFFF_FFFF_FFFF_FFFF);
    check("x31_b", db, 64'hFFFF_FFFF_FFFF_FFFF);
    ra = 5'd18; rb = 5'd18;
    #1;
    check("same_addr_a", da, 64'd672);
    check("same_addr_b", db, 64'd672);

    // Overwrite keeps neighbours intact.
    we = 1'b1; rw = 5'd1; din = 64'h0123_4567_89AB_CDEF;
    edge_step();
    we = 1'b0;
    ra = 5'd1; rb = 5'd7;
    #1;
    check("x1_overwrite", da, 64'h0123_4567_89AB_CDEF);
    check("x7_kept", db, 64'd55);

    // Step 6: asynchronous reset pulse between edges, with a write pending.
    ra = 5'd1; rb = 5'd18;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    we = 1'b1; rw = 5'd18; din = 64'd5;
    #1;
    check("async_rst_a", da, 64'd0);
    check("async_rst_b_no_bypass", db, 64'd0);
    edge_step();
    check("rst_during_edge", db, 64'd0);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_x1", da, 64'd0);
    check("post_rst_x18", db, 64'd0);
    ra = 5'd31; rb = 5'd7;
    #1;
    check("post_rst_x31", da, 64'd0);
    check("post_rst_x7", db, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
